unidad_control_mc: RTL

Parametrised multicycle control FSM for the RV32I datapath and successor to the current control unit. It adds R-type, branches, JAL/JALR, AUIPC, and halfword/byte loads and stores. It also adds illegal-opcode detection and an optional memory-ready stall. It sits between the instruction register/ALU flags and the datapath mux selects and write enables.

---
 rtl/unidad_control_mc_if.sv | 45 ++++
 rtl/unidad_control_mc.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/unidad_control_mc_if.sv
// Control-unit handshake bundle: IR contents and ALU flags in, datapath selects and enables out.
// mem_ready exists only when UC_STALL_EN is defined.
interface unidad_control_mc_if #(
  parameter int ALU_CTRL_W = 4
);
  logic [31:0]           inst;
  logic                  zero;
  logic                  lt;
  logic                  ltu;
`ifdef UC_STALL_EN
  logic                  mem_ready;
`endif
  logic                  pc_w;
  logic                  adr_src;
  logic                  inst_w;
  logic                  mem_w;
  logic                  reg_w;
  logic [1:0]            alu_src_a;
  logic [1:0]            alu_src_b;
  logic [2:0]            imm_src;
  logic [1:0]            result_src;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic [1:0]            ltype;
  logic                  l_unsigned;
  logic [1:0]            stype;
  logic                  illegal;

  modport master (
`ifdef UC_STALL_EN
    input  mem_ready,
`endif
    input  inst, zero, lt, ltu,
    output pc_w, adr_src, inst_w, mem_w, reg_w, alu_src_a, alu_src_b, imm_src,
           result_src, alu_control, ltype, l_unsigned, stype, illegal
  );

  modport slave (
`ifdef UC_STALL_EN
    output mem_ready,
`endif
    output inst, zero, lt, ltu,
    input  pc_w, adr_src, inst_w, mem_w, reg_w, alu_src_a, alu_src_b, imm_src,
           result_src, alu_control, ltype, l_unsigned, stype, illegal
  );
endinterface

// File: rtl/unidad_control_mc.sv
// Multicycle RV32I control FSM: decodes the IR into datapath selects/enables one state per cycle.
// Optional UC_STALL_EN adds mem_ready, stretching FETCH/MEMREAD/MEMWRITE until memory completes.
module unidad_control_mc #(
  parameter int ALU_CTRL_W   = 4,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  unidad_control_mc_if.master  bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_LUI, S_AUIPC, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LINK, S_ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_AND = 4'h2, ALU_OR = 4'h3;
  localparam logic [3:0] ALU_XOR = 4'h4, ALU_SLL = 4'h5, ALU_SRL = 4'h6, ALU_SRA = 4'h7;
  localparam logic [3:0] ALU_SLT = 4'h8, ALU_SLTU = 4'h9, ALU_PASSB = 4'hA;

  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011, IMM_J = 3'b100;

  state_t state_q, state_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7_alt;
  logic       mem_ok;
  logic       unused_inst;

  assign opcode      = bus.inst[6:0];
  assign funct3      = bus.inst[14:12];
  assign f7_alt      = bus.inst[30];
  assign unused_inst = ^{bus.inst[31], bus.inst[29:15], bus.inst[11:7]};

`ifdef UC_STALL_EN
  assign mem_ok = bus.mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  // The alternate funct7 bit means sub only for register ops; shifts honour it for both forms.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt, input logic is_imm);
    logic [3:0] op;
    op = ALU_ADD;
    case (f3)
      3'b000: op = (alt && !is_imm) ? ALU_SUB : ALU_ADD;
      3'b001: op = ALU_SLL;
      3'b010: op = ALU_SLT;
      3'b011: op = ALU_SLTU;
      3'b100: op = ALU_XOR;
      3'b101: op = alt ? ALU_SRA : ALU_SRL;
      3'b110: op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic       pc_w, adr_src, inst_w, mem_w, reg_w, l_unsigned, illegal;
  logic [1:0] alu_src_a, alu_src_b, result_src, ltype, stype;
  logic [2:0] imm_src;
  logic [3:0] alu_code;
  logic       br_taken, br_bad, size_bad, is_store;

  always_comb begin
    br_taken = 1'b0;
    br_bad   = 1'b0;
    case (funct3)
      3'b000:  br_taken = bus.zero;
      3'b001:  br_taken = !bus.zero;
      3'b100:  br_taken = bus.lt;
      3'b101:  br_taken = !bus.lt;
      3'b110:  br_taken = bus.ltu;
      3'b111:  br_taken = !bus.ltu;
      default: br_bad   = 1'b1;
    endcase
  end

  assign size_bad = (funct3[1:0] == 2'b11);
  assign is_store = (opcode == OP_STORE);

  always_comb begin
    state_d    = state_q;
    pc_w       = 1'b0;
    adr_src    = 1'b0;
    inst_w     = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    imm_src    = IMM_I;
    result_src = 2'b00;
    alu_code   = ALU_ADD;
    ltype      = 2'b00;
    l_unsigned = 1'b0;
    stype      = 2'b00;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        pc_w       = mem_ok;
        inst_w     = mem_ok;
        if (mem_ok) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = size_bad ? S_ILLEGAL : S_MEMADR;
          OP_R:      state_d = S_EXECR;
          OP_I:      state_d = S_EXECI;
          OP_LUI:    state_d = S_LUI;
          OP_AUIPC:  state_d = S_AUIPC;
          OP_BRANCH: state_d = S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          OP_JALR:   state_d = S_JALR;
          default:   state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = is_store ? IMM_S : IMM_I;
        if (is_store) begin
          stype   = funct3[1:0];
          state_d = S_MEMWRITE;
        end else begin
          ltype      = funct3[1:0];
          l_unsigned = funct3[2];
          state_d    = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        ltype      = funct3[1:0];
        l_unsigned = funct3[2];
        if (mem_ok) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
        ltype      = funct3[1:0];
        l_unsigned = funct3[2];
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
        stype   = funct3[1:0];
        if (mem_ok) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_code  = alu_op(funct3, f7_alt, 1'b0);
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_code  = alu_op(funct3, f7_alt, 1'b1);
        state_d   = S_ALUWB;
      end
      S_LUI: begin
        alu_src_b = 2'b01;
        imm_src   = IMM_U;
        alu_code  = ALU_PASSB;
        state_d   = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = IMM_U;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        // alu_out still holds the target computed during DECODE.
        alu_src_a = 2'b10;
        alu_code  = ALU_SUB;
        pc_w      = br_taken && !br_bad;
        state_d   = br_bad ? S_ILLEGAL : S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_w      = 1'b1;
        state_d   = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_w       = 1'b1;
        state_d    = S_LINK;
      end
      S_LINK: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = S_ALUWB;
      end
      default: begin
        illegal = 1'b1;
        state_d = ILLEGAL_HALT ? S_ILLEGAL : S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Outputs are forced low for as long as reset is held, independent of the clock.
  assign bus.pc_w        = rst & pc_w;
  assign bus.adr_src     = rst & adr_src;
  assign bus.inst_w      = rst & inst_w;
  assign bus.mem_w       = rst & mem_w;
  assign bus.reg_w       = rst & reg_w;
  assign bus.alu_src_a   = rst ? alu_src_a  : 2'b00;
  assign bus.alu_src_b   = rst ? alu_src_b  : 2'b00;
  assign bus.imm_src     = rst ? imm_src    : 3'b000;
  assign bus.result_src  = rst ? result_src : 2'b00;
  assign bus.alu_control = rst ? ALU_CTRL_W'(alu_code) : '0;
  assign bus.ltype       = rst ? ltype      : 2'b00;
  assign bus.l_unsigned  = rst & l_unsigned;
  assign bus.stype       = rst ? stype      : 2'b00;
  assign bus.illegal     = rst & illegal;

endmodule
